hamming_stream_decoder: RTL and testbench

// - Receive-side counterpart of the Hamming(7,4) counter encoder: accepts a stream of
//   per-nibble Hamming-protected words and returns corrected data plus error flags.
// - 2-stage valid/ready pipeline between the encoded-word source and the consumer.
// - Sits downstream of the counter/parity store; an optional counter tracks corrections.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming_block_fix.sv | 25 ++
 rtl/hamming_stream_decoder.sv | 136 +++++++++++++
 tb/tb_hamming_stream_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) types, syndrome codes and the shared per-nibble encoder
package hamming_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [2:0] par3_t;

    // Syndrome produced by a single flipped bit: data bits first, then parity bits
    localparam par3_t SYN_D0 = 3'b111;
    localparam par3_t SYN_D1 = 3'b011;
    localparam par3_t SYN_D2 = 3'b101;
    localparam par3_t SYN_D3 = 3'b110;
    localparam par3_t SYN_P0 = 3'b001;
    localparam par3_t SYN_P1 = 3'b010;
    localparam par3_t SYN_P2 = 3'b100;

    // Same equations as the encoder side so stored parity and recomputed parity line up
    function automatic par3_t enc_block(input nibble_t d);
        return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
    endfunction

endpackage

// File: rtl/hamming_block_fix.sv
// rtl/hamming_block_fix.sv - combinational single-error correction for one 4-bit block
module hamming_block_fix
    import hamming_pkg::*;
(
    input  par3_t   syn_i,
    input  nibble_t nibble_i,
    output nibble_t nibble_o,
    output logic    err_o
);

    // Flip the data bit named by the syndrome; parity-only syndromes leave data as-is
    always_comb begin
        nibble_o = nibble_i;
        err_o    = (syn_i != 3'b000);
        case (syn_i)
            SYN_D0:                 nibble_o[0] = ~nibble_i[0];
            SYN_D1:                 nibble_o[1] = ~nibble_i[1];
            SYN_D2:                 nibble_o[2] = ~nibble_i[2];
            SYN_D3:                 nibble_o[3] = ~nibble_i[3];
            SYN_P0, SYN_P1, SYN_P2: nibble_o    = nibble_i;
            default:                nibble_o    = nibble_i;
        endcase
    end

endmodule

// File: rtl/hamming_stream_decoder.sv
// rtl/hamming_stream_decoder.sv - 2-stage Hamming(7,4) stream decoder; HAMMING_ERR_CNT_EN enables err_count
module hamming_stream_decoder
    import hamming_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BLOCKS      = WIDTH / 4,
    parameter int PARITY_BITS = BLOCKS * 3,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    input  logic [PARITY_BITS-1:0] s_parity,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic [BLOCKS-1:0]      m_corr_mask,
    output logic                   m_err,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       err_count
);

    logic                   s1_adv, s2_adv;
    logic                   s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]       s1_data_q, s1_data_d;
    logic [PARITY_BITS-1:0] s1_syn_q, s1_syn_d;
    logic [PARITY_BITS-1:0] syn_in;
    logic [WIDTH-1:0]       fix_data;
    logic [BLOCKS-1:0]      fix_mask;
    logic                   m_valid_q, m_valid_d;
    logic [WIDTH-1:0]       m_data_q, m_data_d;
    logic [BLOCKS-1:0]      m_mask_q, m_mask_d;
    logic                   m_err_q, m_err_d;

    // Syndrome is computed on the incoming word; correction happens one stage later
    for (genvar b = 0; b < BLOCKS; b++) begin : g_blk
        assign syn_in[3*b +: 3] = enc_block(s_data[4*b +: 4]) ^ s_parity[3*b +: 3];

        hamming_block_fix u_fix (
            .syn_i   (s1_syn_q[3*b +: 3]),
            .nibble_i(s1_data_q[4*b +: 4]),
            .nibble_o(fix_data[4*b +: 4]),
            .err_o   (fix_mask[b])
        );
    end

    // Ready chain runs back from the consumer so a full pipe still moves every cycle
    assign s2_adv  = !m_valid_q || m_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign s_ready = s1_adv;

    // Next state of both pipeline stages
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_mask_d   = m_mask_q;
        m_err_d    = m_err_q;
        if (s1_adv) begin
            s1_valid_d = s_valid;
            if (s_valid) begin
                s1_data_d = s_data;
                s1_syn_d  = syn_in;
            end
        end
        if (s2_adv) begin
            m_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                m_data_d = fix_data;
                m_mask_d = fix_mask;
                m_err_d  = |fix_mask;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_mask_q   <= '0;
            m_err_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_syn_q   <= s1_syn_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_mask_q   <= m_mask_d;
            m_err_q    <= m_err_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_corr_mask = m_mask_q;
    assign m_err       = m_err_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count delivered words that needed correction; clear wins, saturate at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (m_valid_q && m_ready && m_err_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Correction counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// tb/tb_hamming_stream_decoder.sv - self-checking bench for hamming_stream_decoder
module tb_hamming_stream_decoder;

    localparam int CNT_ON =
`ifdef HAMMING_ERR_CNT_EN
        1;
`else
        0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [23:0] s_parity = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [7:0]  m_corr_mask;
    logic        m_err;
    logic        cnt_clr = 1'b0;
    logic [15:0] err_count;

    logic        s_ready2, m_valid2, m_err2;
    logic [31:0] m_data2;
    logic [7:0]  m_mask2;
    logic [1:0]  err_count2;

    hamming_stream_decoder #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_parity(s_parity), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_corr_mask(m_corr_mask), .m_err(m_err), .cnt_clr(cnt_clr), .err_count(err_count)
    );

    hamming_stream_decoder #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
        .s_parity(s_parity), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
        .m_corr_mask(m_mask2), .m_err(m_err2), .cnt_clr(cnt_clr), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [23:0] p;
        logic [31:0] ed;
        logic [7:0]  em;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  m;
    } exp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   cnt_m = 0;
    int   cnt2_m = 0;
    logic accepted = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [7:0]  prev_mask;
    exp_t q[$];
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] benc(input logic [3:0] d);
        return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
    endfunction

    function automatic logic [23:0] enc_word(input logic [31:0] d);
        logic [23:0] p;
        for (int b = 0; b < 8; b++) p[3*b +: 3] = benc(d[4*b +: 4]);
        return p;
    endfunction

    // A single flipped data bit j yields syndrome enc(1<<j) by linearity of the code
    function automatic void ref_dec(input logic [31:0] d, input logic [23:0] p,
                                    output logic [31:0] od, output logic [7:0] om);
        od = d;
        om = '0;
        for (int b = 0; b < 8; b++) begin
            logic [2:0] syn;
            syn = benc(d[4*b +: 4]) ^ p[3*b +: 3];
            om[b] = (syn != 3'b000);
            for (int j = 0; j < 4; j++) begin
                logic [3:0] one;
                one = 4'b0001 << j;
                if (syn != 3'b000 && benc(one) == syn) od[4*b + j] = ~d[4*b + j];
            end
        end
    endfunction

    task automatic mon();
        exp_t e;
        logic hs_err;
        if (rst) return;
        if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
            chk("hold_mask", m_corr_mask, prev_mask);
        end
        chk("err_count", err_count, (CNT_ON != 0) ? cnt_m : 0);
        chk("err_count_w2", err_count2, (CNT_ON != 0) ? cnt2_m : 0);
        accepted = s_valid && s_ready;
        if (accepted) begin
            ref_dec(s_data, s_parity, e.d, e.m);
            q.push_back(e);
        end
        hs_err = 1'b0;
        if (m_valid && m_ready) begin
            n_out++;
            chk("out_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_data", m_data, e.d);
                chk("sb_mask", m_corr_mask, e.m);
                chk("sb_err", m_err, |e.m);
                hs_err = |e.m;
            end
        end
        if (cnt_clr) begin
            cnt_m = 0;
            cnt2_m = 0;
        end else if (hs_err) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt2_m < 3) cnt2_m++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_mask  = m_corr_mask;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send_err();
        s_valid = 1'b1; s_data = 32'h0; s_parity = 24'h000007; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        step();
    endtask

    task automatic model_reset();
        q.delete();
        cnt_m = 0;
        cnt2_m = 0;
        prev_stall = 1'b0;
        accepted = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n0;
        vecs[0] = '{32'h0000_0001, 24'h000007, 32'h0000_0001, 8'h00};
        vecs[1] = '{32'h0000_0000, 24'h000007, 32'h0000_0001, 8'h01};
        vecs[2] = '{32'h0000_0000, 24'h000001, 32'h0000_0000, 8'h01};
        vecs[3] = '{32'h8000_0000, 24'h000000, 32'h0000_0000, 8'h80};
        vecs[4] = '{32'h0000_0000, 24'h000400, 32'h0000_0000, 8'h08};
        vecs[5] = '{32'hFFFF_FBFF, 24'hFFFFFF, 32'hFFFF_FFFF, 8'h04};
        vecs[6] = '{32'h0000_0010, 24'h000001, 32'h0000_0000, 8'h03};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_mask", m_corr_mask, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_s_ready", s_ready, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // directed vectors with latency check
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = vecs[i].d; s_parity = vecs[i].p; m_ready = 1'b1;
            step();
            s_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), m_valid, 0);
            step();
            chk($sformatf("vec%0d_valid", i), m_valid, 1);
            chk($sformatf("vec%0d_data", i), m_data, vecs[i].ed);
            chk($sformatf("vec%0d_mask", i), m_corr_mask, vecs[i].em);
            chk($sformatf("vec%0d_err", i), m_err, vecs[i].em != 0);
            step();
        end

        // counter: three errors, clear colliding with a fourth, then saturation
        rst = 1'b1;
        #3;
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send_err();
        chk("cnt_after3", err_count, (CNT_ON != 0) ? 3 : 0);
        chk("cnt2_after3", err_count2, (CNT_ON != 0) ? 3 : 0);
        s_valid = 1'b1; s_data = 32'h0; s_parity = 24'h000007;
        step();
        s_valid = 1'b0;
        step();
        chk("clr_setup_valid", m_valid, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", err_count, 0);
        chk("cnt2_clr_priority", err_count2, 0);
        for (int i = 0; i < 5; i++) send_err();
        chk("cnt_after5", err_count, (CNT_ON != 0) ? 5 : 0);
        chk("cnt2_saturated", err_count2, (CNT_ON != 0) ? 3 : 0);

        // back-to-back under stall
        m_ready = 1'b0;
        k = 0;
        n0 = n_out;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = 32'hA5A5_0000 + k;
            s_parity = enc_word(s_data) ^ ((k == 1) ? 24'h000010 : 24'h0);
            step();
            if (accepted) k++;
        end
        chk("stall_accepted", k, 2);
        chk("stall_s_ready", s_ready, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 20 && k < 4; i++) begin
            s_valid = 1'b1;
            s_data = 32'hA5A5_0000 + k;
            s_parity = enc_word(s_data) ^ ((k == 3) ? 24'h800000 : 24'h0);
            step();
            if (accepted) k++;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        step();
        chk("stall_all_out", n_out - n0, 4);

        // async reset with m_valid=1 and S1 full
        m_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 6 && k < 2; i++) begin
            s_valid = 1'b1; s_data = 32'h1234_5670 + k; s_parity = enc_word(s_data);
            step();
            if (accepted) k++;
        end
        s_valid = 1'b0;
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_s1_full", s_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_err_count2", err_count2, 0);
        chk("arst_s_ready", s_ready, 1);
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b1; s_data = 32'h0; s_parity = 24'h000007; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        chk("post_rst_valid", m_valid, 1);
        chk("post_rst_data", m_data, 32'h0000_0001);
        chk("post_rst_mask", m_corr_mask, 8'h01);
        step();

        // randomized traffic against the reference model
        accepted = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 63) == 0);
            if (!s_valid || accepted) begin
                int pos;
                s_valid = ($urandom_range(0, 2) != 0);
                s_data = $urandom;
                s_parity = enc_word(s_data);
                if ($urandom_range(0, 2) == 0) begin
                    pos = $urandom_range(0, 55);
                    if (pos < 32) s_data[pos] = ~s_data[pos];
                    else s_parity[pos-32] = ~s_parity[pos-32];
                end
                if ($urandom_range(0, 7) == 0) begin
                    pos = $urandom_range(0, 55);
                    if (pos < 32) s_data[pos] = ~s_data[pos];
                    else s_parity[pos-32] = ~s_parity[pos-32];
                end
            end
            step();
        end
        s_valid = 1'b0;
        cnt_clr = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
